// File: rtl/result_unloader.sv
// Drains the result vector from byte-addressed data memory after the core
// finishes. Each result word is assembled big-endian and then presented
// on a valid/ready stream. The core cycle count is latched at start.
module result_unloader #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = ROWS*COLS*4 + COLS*4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    done,
    input  logic [15:0]             clock_count,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [7:0]              mem_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic [$clog2(ROWS):0]   out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    complete,
    output logic [15:0]             cycles_latched
);

    localparam int unsigned IDX_W = $clog2(ROWS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        byte_cnt;
    logic              is_last_word;

    assign is_last_word = (idx == IDX_W'(ROWS - 1));
    assign out_index    = idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        complete  = 1'b0;
        case (state)
            S_IDLE: begin
                if (done) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = ADDR_W'(BASE_ADDR) + (ADDR_W'(idx) << 2) + ADDR_W'(byte_cnt);
                busy      = 1'b1;
                if (byte_cnt == 2'd3) begin
                    state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                busy      = 1'b1;
                state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                out_valid = 1'b1;
                out_last  = is_last_word;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = is_last_word ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                complete = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Word assembly, index/byte counters and cycle-count latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            byte_cnt       <= '0;
            out_data       <= '0;
            cycles_latched <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (done) begin
                        idx            <= '0;
                        byte_cnt       <= '0;
                        cycles_latched <= clock_count;
                    end
                end
                S_FETCH: begin
                    // The first shift carries a stale byte that is pushed out by the last one.
                    byte_cnt <= byte_cnt + 2'd1;
                    out_data <= {out_data[23:0], mem_rd_data};
                end
                S_LAST: begin
                    out_data <= {out_data[23:0], mem_rd_data};
                end
                S_PRESENT: begin
                    if (out_ready && !is_last_word) begin
                        idx      <= idx + IDX_W'(1);
                        byte_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: a ROWS=2/COLS=2 instance for timing,
// backpressure and reset, and a default-parameter instance for a full drain.
module tb_result_unloader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A: ROWS=2, COLS=2 ----------------
    logic        rst_n_a, done_a, ready_a, rd_en_a, valid_a, last_a, busy_a, complete_a;
    logic [15:0] cc_a, addr_a, lat_a;
    logic [7:0]  rd_data_a;
    logic [31:0] data_a;
    logic [1:0]  index_a;
    logic [7:0]  mem_a [0:255];
    logic [15:0] strobes_a [$];

    result_unloader #(.ROWS(2), .COLS(2), .ADDR_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .done(done_a), .clock_count(cc_a),
        .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(rd_data_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
        .out_index(index_a), .out_last(last_a), .busy(busy_a),
        .complete(complete_a), .cycles_latched(lat_a)
    );

    always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[addr_a[7:0]];
    always @(negedge clk) if (rd_en_a) strobes_a.push_back(addr_a);

    // ---------------- instance B: default parameters ----------------
    logic        rst_n_b, done_b, ready_b, rd_en_b, valid_b, last_b, busy_b, complete_b;
    logic [15:0] cc_b, addr_b, lat_b;
    logic [7:0]  rd_data_b;
    logic [31:0] data_b;
    logic [2:0]  index_b;
    logic [7:0]  mem_b [0:255];
    logic [15:0] strobes_b [$];

    typedef struct {
        logic [31:0] data;
        logic [2:0]  index;
        logic        last;
    } word_t;
    word_t accepted_b [$];

    result_unloader dut_b (
        .clk(clk), .rst_n(rst_n_b), .done(done_b), .clock_count(cc_b),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rd_data_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
        .out_index(index_b), .out_last(last_b), .busy(busy_b),
        .complete(complete_b), .cycles_latched(lat_b)
    );

    always @(posedge clk) if (rd_en_b) rd_data_b <= mem_b[addr_b[7:0]];
    always @(negedge clk) begin
        if (rd_en_b) strobes_b.push_back(addr_b);
        if (valid_b && ready_b) accepted_b.push_back('{data_b, index_b, last_b});
    end

    // Per-cycle expectation for instance A, indexed by edges after the start edge
    typedef struct {
        logic        valid;
        logic        busy;
        logic        complete;
        logic [31:0] data;
        logic [1:0]  index;
        logic        last;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic b, input logic c,
                                input logic [31:0] d, input logic [1:0] i, input logic l);
        vec_t r;
        r.valid = v; r.busy = b; r.complete = c; r.data = d; r.index = i; r.last = l;
        return r;
    endfunction

    initial begin
        vec_t  trace [0:12];
        word_t words_b [0:3];
        int    n;
        int    n0;

        trace[0]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[1]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[2]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[3]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[4]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[5]  = mk(1, 1, 0, 32'h0000_0011, 2'd0, 0);
        trace[6]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[7]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[8]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[9]  = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[10] = mk(0, 1, 0, 32'h0, 2'd0, 0);
        trace[11] = mk(1, 1, 0, 32'hFFFF_FFFE, 2'd1, 1);
        trace[12] = mk(0, 0, 1, 32'h0, 2'd0, 0);

        words_b[0] = '{32'h1234_5678, 3'd0, 1'b0};
        words_b[1] = '{32'h8000_0001, 3'd1, 1'b0};
        words_b[2] = '{32'hDEAD_BEEF, 3'd2, 1'b0};
        words_b[3] = '{32'h00FF_00FF, 3'd3, 1'b1};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h5A;
            mem_b[i] = 8'hA5;
        end
        mem_a[24] = 8'h00; mem_a[25] = 8'h00; mem_a[26] = 8'h00; mem_a[27] = 8'h11;
        mem_a[28] = 8'hFF; mem_a[29] = 8'hFF; mem_a[30] = 8'hFF; mem_a[31] = 8'hFE;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                mem_b[80 + 4*w + b] = words_b[w].data[31 - 8*b -: 8];
            end
        end

        rst_n_a = 1'b0; done_a = 1'b0; ready_a = 1'b1; cc_a = 16'h0;
        rst_n_b = 1'b0; done_b = 1'b0; ready_b = 1'b1; cc_b = 16'h0;
        rd_data_a = 8'h0; rd_data_b = 8'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_complete", 32'(complete_a), 0);
        chk("rst_rd_en", 32'(rd_en_a), 0);
        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_data", data_a, 0);
        chk("rst_latched", 32'(lat_a), 0);
        chk("rst_last", 32'(last_a), 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Full drain of instance A with out_ready held high, done pulsed
        @(negedge clk);
        strobes_a.delete();
        cc_a   = 16'h01A3;
        done_a = 1'b1;
        @(posedge clk); #1;
        done_a = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            cc_a = cc_a + 16'd1;
            chk($sformatf("a_valid_c%0d", c), 32'(valid_a), 32'(trace[c].valid));
            chk($sformatf("a_busy_c%0d", c), 32'(busy_a), 32'(trace[c].busy));
            chk($sformatf("a_complete_c%0d", c), 32'(complete_a), 32'(trace[c].complete));
            if (trace[c].valid) begin
                chk($sformatf("a_data_c%0d", c), data_a, trace[c].data);
                chk($sformatf("a_index_c%0d", c), 32'(index_a), 32'(trace[c].index));
                chk($sformatf("a_last_c%0d", c), 32'(last_a), 32'(trace[c].last));
            end
        end
        chk("a_latched", 32'(lat_a), 32'h01A3);
        chk("a_strobe_count", strobes_a.size(), 8);
        for (int i = 0; i < 8 && i < strobes_a.size(); i++) begin
            chk($sformatf("a_strobe%0d", i), 32'(strobes_a[i]), 32'(24 + i));
        end

        // done toggled after complete must not start another drain
        n0 = strobes_a.size();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_a = ~done_a;
        end
        @(negedge clk);
        done_a = 1'b0;
        chk("a_no_reads_after_complete", strobes_a.size(), n0);
        chk("a_complete_sticky", 32'(complete_a), 1);
        chk("a_busy_after_complete", 32'(busy_a), 0);
        chk("a_latched_hold", 32'(lat_a), 32'h01A3);

        // Backpressure: restart via reset, hold out_ready low while presenting
        @(negedge clk);
        rst_n_a = 1'b0;
        ready_a = 1'b0;
        done_a  = 1'b1;
        @(negedge clk);
        rst_n_a = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!valid_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", n, 5);
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", k), 32'(valid_a), 1);
            chk($sformatf("bp_data_%0d", k), data_a, 32'h0000_0011);
            chk($sformatf("bp_index_%0d", k), 32'(index_a), 0);
            chk($sformatf("bp_last_%0d", k), 32'(last_a), 0);
            chk($sformatf("bp_rd_en_%0d", k), 32'(rd_en_a), 0);
        end
        ready_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_word1_rd_en", 32'(rd_en_a), 1);
        chk("bp_word1_addr0", 32'(addr_a), 28);
        @(posedge clk); #1;
        chk("bp_word1_addr1", 32'(addr_a), 29);

        // Asynchronous reset in the middle of fetching word 1
        #2;
        rst_n_a = 1'b0;
        #1;
        strobes_a.delete();
        chk("mid_rst_valid", 32'(valid_a), 0);
        chk("mid_rst_busy", 32'(busy_a), 0);
        chk("mid_rst_complete", 32'(complete_a), 0);
        chk("mid_rst_rd_en", 32'(rd_en_a), 0);
        chk("mid_rst_addr", 32'(addr_a), 0);
        chk("mid_rst_data", data_a, 0);
        chk("mid_rst_index", 32'(index_a), 0);
        chk("mid_rst_latched", 32'(lat_a), 0);
        @(negedge clk);
        rst_n_a = 1'b1;
        @(posedge clk); #1;
        chk("restart_rd_en", 32'(rd_en_a), 1);
        chk("restart_addr", 32'(addr_a), 24);
        n = 0;
        while (!complete_a && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        done_a = 1'b0;
        chk("restart_complete", 32'(complete_a), 1);
        chk("restart_strobe_count", strobes_a.size(), 8);
        if (strobes_a.size() > 0) chk("restart_first_strobe", 32'(strobes_a[0]), 24);

        // Default-parameter instance: four words, done falls right after start
        @(negedge clk);
        strobes_b.delete();
        accepted_b.delete();
        cc_b   = 16'h0042;
        done_b = 1'b1;
        @(posedge clk); #1;
        done_b = 1'b0;
        cc_b   = 16'h7777;
        n = 0;
        while (!complete_b && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_drain_cycles", n, 24);
        chk("b_busy_end", 32'(busy_b), 0);
        chk("b_latched", 32'(lat_b), 32'h0042);
        chk("b_strobe_count", strobes_b.size(), 16);
        for (int i = 0; i < 16 && i < strobes_b.size(); i++) begin
            chk($sformatf("b_strobe%0d", i), 32'(strobes_b[i]), 32'(80 + i));
        end
        chk("b_word_count", accepted_b.size(), 4);
        for (int w = 0; w < 4 && w < accepted_b.size(); w++) begin
            chk($sformatf("b_data%0d", w), accepted_b[w].data, words_b[w].data);
            chk($sformatf("b_index%0d", w), 32'(accepted_b[w].index), 32'(words_b[w].index));
            chk($sformatf("b_last%0d", w), 32'(accepted_b[w].last), 32'(words_b[w].last));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
